// File: rtl/dev_fifo_pkg.sv
// Shared types for the per-device bus ingress FIFO: packet layout and the helper that
// extracts the destination id.
package dev_fifo_pkg;
    localparam int ID_W      = 8;
    localparam int PKT_W     = 24;
    localparam int PAYLOAD_W = PKT_W - ID_W;

    typedef struct packed {
        logic [ID_W-1:0]      dest;
        logic [PAYLOAD_W-1:0] payload;
    } pkt_t;

    function automatic logic [ID_W-1:0] dest_of(input pkt_t p);
        return p.dest;
    endfunction
endpackage

// File: rtl/dev_fifo_mem.sv
// Packet storage for dev_fifo_bus: one synchronous write port and one asynchronous read port.
// Contents are never cleared; validity is tracked by the pointers and count in the parent.
module dev_fifo_mem #(
    parameter int W  = 24,
    parameter int N  = 16,
    parameter int AW = $clog2(N)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [W-1:0]  i_wr_data,
    input  logic [AW-1:0] i_rd_addr,
    output logic [W-1:0]  o_rd_data
);
    logic [W-1:0] r_mem [N];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];
endmodule

// File: rtl/dev_fifo_bus.sv
// Per-device show-ahead ingress FIFO feeding one bus arbiter port. Defining DEV_FIFO_STATS_EN
// adds the drop_cnt and hwm statistics outputs; otherwise rejected pushes are silent.
module dev_fifo_bus
    import dev_fifo_pkg::*;
#(
    parameter int pckg_sz = 24,
    parameter int depth   = 16,
    parameter int id      = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [pckg_sz-1:0]         D_push,
    output logic                       full,
    output logic [$clog2(depth+1)-1:0] count,
    output logic                       pndng,
    input  logic                       pop,
    output logic [pckg_sz-1:0]         D_pop
`ifdef DEV_FIFO_STATS_EN
    ,
    output logic [15:0]                drop_cnt,
    output logic [$clog2(depth+1)-1:0] hwm
`endif
);
    localparam int CW = $clog2(depth + 1);
    localparam int PW = $clog2(depth);

    logic [PW-1:0]      r_rd_ptr, r_wr_ptr;
    logic [CW-1:0]      r_count;
    logic               r_full, r_pndng;
    logic [pckg_sz-1:0] r_d_pop;

    logic               w_push_acc, w_pop_acc;
    logic [PW-1:0]      w_rd_ptr_next, w_wr_ptr_next;
    logic [CW-1:0]      w_count_next;
    logic [pckg_sz-1:0] w_mem_rd, w_d_pop_next;

    // The device index only tags this instance; it does not affect datapath behaviour.
    logic [ID_W-1:0]    w_unused_dev_id;
    assign w_unused_dev_id = ID_W'(id);

    assign w_pop_acc  = pop & r_pndng;
    assign w_push_acc = push & (~r_full | w_pop_acc);

    assign w_rd_ptr_next = (r_rd_ptr == PW'(depth - 1)) ? '0 : r_rd_ptr + 1'b1;
    assign w_wr_ptr_next = (r_wr_ptr == PW'(depth - 1)) ? '0 : r_wr_ptr + 1'b1;

    always_comb begin
        w_count_next = r_count;
        if (w_push_acc && !w_pop_acc) begin
            w_count_next = r_count + 1'b1;
        end else if (!w_push_acc && w_pop_acc) begin
            w_count_next = r_count - 1'b1;
        end
    end

    dev_fifo_mem #(
        .W (pckg_sz),
        .N (depth),
        .AW(PW)
    ) u_mem (
        .clk      (clk),
        .i_we     (w_push_acc),
        .i_wr_addr(r_wr_ptr),
        .i_wr_data(D_push),
        .i_rd_addr(w_rd_ptr_next),
        .o_rd_data(w_mem_rd)
    );

    // Next head: a lone entry being replaced by a same-edge push is not in storage yet,
    // so it is bypassed straight from D_push.
    always_comb begin
        w_d_pop_next = r_d_pop;
        if (w_pop_acc) begin
            if (w_count_next == '0) begin
                w_d_pop_next = '0;
            end else if (r_count == CW'(1)) begin
                w_d_pop_next = D_push;
            end else begin
                w_d_pop_next = w_mem_rd;
            end
        end else if (w_push_acc && r_count == '0) begin
            w_d_pop_next = D_push;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_pndng  <= 1'b0;
            r_d_pop  <= '0;
        end else begin
            if (w_pop_acc) begin
                r_rd_ptr <= w_rd_ptr_next;
            end
            if (w_push_acc) begin
                r_wr_ptr <= w_wr_ptr_next;
            end
            r_count <= w_count_next;
            r_full  <= (w_count_next == CW'(depth));
            r_pndng <= (w_count_next != '0);
            r_d_pop <= w_d_pop_next;
        end
    end

    assign full  = r_full;
    assign count = r_count;
    assign pndng = r_pndng;
    assign D_pop = r_d_pop;

`ifdef DEV_FIFO_STATS_EN
    logic [15:0]   r_drop_cnt;
    logic [CW-1:0] r_hwm;
    logic          w_drop;

    assign w_drop = push & ~w_push_acc;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_drop_cnt <= '0;
            r_hwm      <= '0;
        end else begin
            if (w_drop && r_drop_cnt != 16'hFFFF) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
            if (w_count_next > r_hwm) begin
                r_hwm <= w_count_next;
            end
        end
    end

    assign drop_cnt = r_drop_cnt;
    assign hwm      = r_hwm;
`endif
endmodule

// File: tb/tb_dev_fifo_bus.sv
// Randomized and directed bench for dev_fifo_bus against a queue-based reference model.
module tb_dev_fifo_bus;
    import dev_fifo_pkg::*;

    localparam int PS    = 24;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          reset, push, pop;
    logic [PS-1:0] D_push, D_pop;
    logic          full, pndng;
    logic [CW-1:0] count;
`ifdef DEV_FIFO_STATS_EN
    logic [15:0]   drop_cnt;
    logic [CW-1:0] hwm;
`endif

    always #5 clk = ~clk;

    dev_fifo_bus #(
        .pckg_sz(PS),
        .depth  (DEPTH),
        .id     (2)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .D_push  (D_push),
        .full    (full),
        .count   (count),
        .pndng   (pndng),
        .pop     (pop),
        .D_pop   (D_pop)
`ifdef DEV_FIFO_STATS_EN
        ,
        .drop_cnt(drop_cnt),
        .hwm     (hwm)
`endif
    );

    int            n_total = 0;
    int            n_bad   = 0;
    logic [PS-1:0] m_q[$];
    int            m_drops = 0;
    int            m_hwm   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        logic [PS-1:0] head;
        head = (m_q.size() > 0) ? m_q[0] : '0;
        check({tag, ".count"}, 32'(count), 32'(m_q.size()));
        check({tag, ".full"},  32'(full),  32'(m_q.size() == DEPTH));
        check({tag, ".pndng"}, 32'(pndng), 32'(m_q.size() != 0));
        check({tag, ".D_pop"}, 32'(D_pop), 32'(head));
`ifdef DEV_FIFO_STATS_EN
        check({tag, ".drop_cnt"}, 32'(drop_cnt), 32'(m_drops));
        check({tag, ".hwm"},      32'(hwm),      32'(m_hwm));
`endif
    endtask

    // Reference: a bounded queue; a pop frees a slot for a same-edge push.
    task automatic model_step(input logic p, input logic [PS-1:0] d, input logic po);
        bit pop_acc, push_acc;
        pop_acc  = po && (m_q.size() > 0);
        push_acc = p && ((m_q.size() < DEPTH) || pop_acc);
        if (p && !push_acc && m_drops < 65535) m_drops++;
        if (pop_acc) void'(m_q.pop_front());
        if (push_acc) m_q.push_back(d);
        if (m_q.size() > m_hwm) m_hwm = m_q.size();
    endtask

    task automatic cycle(input logic p, input logic [PS-1:0] d, input logic po, input string tag);
        push   = p;
        D_push = d;
        pop    = po;
        @(posedge clk);
        model_step(p, d, po);
        #1;
        push = 1'b0;
        pop  = 1'b0;
        $display("%s: push=%0b d=%06h pop=%0b -> count=%0d pndng=%0b D_pop=%06h",
                 tag, p, d, po, count, pndng, D_pop);
        check_state(tag);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        @(posedge clk);
        m_q.delete();
        m_drops = 0;
        m_hwm   = 0;
        #1;
        reset = 1'b0;
        $display("%s: reset -> count=%0d pndng=%0b D_pop=%06h", tag, count, pndng, D_pop);
        check_state(tag);
    endtask

    initial begin
        reset  = 1'b1;
        push   = 1'b0;
        pop    = 1'b0;
        D_push = '0;

        // 1: reset then idle
        do_reset("t1_reset");
        for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b0, "t1_idle");

        // 2: single push, show-ahead next cycle
        cycle(1'b1, 24'h03ABCD, 1'b0, "t2_push");
        check("t2_dpop_const", 32'(D_pop), 32'h0003ABCD);
        check("t2_dest", 32'(dest_of(pkt_t'(D_pop))), 32'd3);
        cycle(1'b0, '0, 1'b1, "t2_pop");

        // 3: overfill by one, then drain in order
        for (int i = 0; i <= 16; i++) cycle(1'b1, PS'(i), 1'b0, "t3_fill");
        check("t3_full_const", 32'(full), 32'd1);
        for (int i = 0; i < 16; i++) begin
            check("t3_order", 32'(D_pop), 32'(i));
            cycle(1'b0, '0, 1'b1, "t3_drain");
        end
        check("t3_empty_const", 32'(pndng), 32'd0);

        // 4: push+pop while full
        for (int i = 0; i < 16; i++) cycle(1'b1, PS'(24'h100 + i), 1'b0, "t4_fill");
        cycle(1'b1, 24'h0AAAAA, 1'b1, "t4_pushpop");
        check("t4_count_const", 32'(count), 32'd16);
        for (int i = 0; i < 16; i++) cycle(1'b0, '0, 1'b1, "t4_drain");

        // 5: pop on empty with simultaneous push
        cycle(1'b1, 24'h050001, 1'b1, "t5_pushpop_empty");
        check("t5_dpop_const", 32'(D_pop), 32'h00050001);

        // 6: reset mid-operation, then traffic that crosses the wrap point
        for (int i = 0; i < 4; i++) cycle(1'b1, PS'(24'h600 + i), 1'b0, "t6_fill");
        do_reset("t6_reset");
        for (int i = 0; i < 3; i++) cycle(1'b1, PS'(24'h700 + i), 1'b0, "t6_push3");
        for (int i = 0; i < 40; i++) cycle(1'b1, PS'(24'h800 + i), 1'b1, "t6_wrap");

        // random phases: fill-biased, drain-biased, balanced; rare resets
        for (int i = 0; i < 600; i++) begin
            int phase;
            logic p, po;
            phase = (i / 50) % 3;
            p  = ($urandom_range(99) < ((phase == 0) ? 80 : (phase == 1) ? 20 : 50));
            po = ($urandom_range(99) < ((phase == 0) ? 20 : (phase == 1) ? 80 : 50));
            if ($urandom_range(199) == 0) do_reset("rnd_reset");
            else cycle(p, PS'($urandom), po, "rnd");
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
